conv_pool_sched: RTL



---
 rtl/conv_pool_sched_pkg.sv | 29 ++
 rtl/conv_pool_sched_if.sv | 34 +++
 rtl/conv_pool_sched_addr_gen.sv | 83 ++++++++
 rtl/conv_pool_sched.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/conv_pool_sched_pkg.sv
// conv_pool_pkg: shared FSM state codes, default layer geometry totals
// and the clog2 counter-width helper for the CONV_POOL layer scheduler.
package conv_pool_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_START = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // Default geometry: CI*IFM_SIZE^2, CO*CI*KERNEL_SIZE^2, CO*FINAL_SIZE^2
  localparam int IFM_TOTAL = 3 * 13 * 13;
  localparam int WGT_TOTAL = 16 * 3 * 3 * 3;
  localparam int OFM_TOTAL = 16 * 6 * 6;

  // Smallest r with 2**r >= value
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_pool_sched_if.sv
// conv_pool_sched_if: command channel plus datapath request/result stream
// between a layer driver and the conv_pool_sched scheduler.
interface conv_pool_sched_if #(
  parameter int IFM_WIDTH    = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 18
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_WIDTH-1:0]   cmd_ifm_base;
  logic [ADDR_WIDTH-1:0]   cmd_wgt_base;
  logic [ADDR_WIDTH-1:0]   cmd_ofm_base;
  logic                    start_conv;
  logic                    ifm_read;
  logic                    wgt_read;
  logic [IFM_WIDTH-1:0]    ifm;
  logic [WEIGHT_WIDTH-1:0] wgt;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   data_output;
  logic                    end_pool;

  modport slave (
    input  cmd_valid, cmd_ifm_base, cmd_wgt_base, cmd_ofm_base,
    input  ifm_read, wgt_read, out_valid, data_output, end_pool,
    output cmd_ready, start_conv, ifm, wgt
  );

  modport master (
    output cmd_valid, cmd_ifm_base, cmd_wgt_base, cmd_ofm_base,
    output ifm_read, wgt_read, out_valid, data_output, end_pool,
    input  cmd_ready, start_conv, ifm, wgt
  );
endinterface

// File: rtl/conv_pool_sched_addr_gen.sv
// sched_addr_gen: base + running count address generator. WRAP=1 wraps the
// count after TOTAL-1; WRAP=0 saturates at TOTAL and refuses further accesses.
// REG_DATA=1 zeroes data_o except the cycle after an accepted read (SRAM
// latency); REG_DATA=0 passes data_i through only while an access is accepted.
module sched_addr_gen
  import conv_pool_pkg::*;
#(
  parameter int AW       = 18,
  parameter int DW       = 16,
  parameter int TOTAL    = 507,
  parameter bit WRAP     = 1'b1,
  parameter bit REG_DATA = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          req,
  input  logic [AW-1:0] base,
  input  logic [DW-1:0] data_i,
  output logic          en_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          full_nxt_o
);
  localparam int CW = clog2(TOTAL + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_s, last_s;

  assign full_s     = (cnt_q == CW'(TOTAL));
  assign last_s     = (cnt_q == CW'(TOTAL - 1));
  assign en_o       = req & ~full_s;
  assign addr_o     = base + AW'(cnt_q);
  assign full_nxt_o = (cnt_d == CW'(TOTAL));

  // Next count: cleared per layer, advanced per accepted access, optional wrap
  always_comb begin
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en_o && WRAP && last_s) begin
      cnt_d = {CW{1'b0}};
    end else if (en_o) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  if (REG_DATA) begin : g_reg
    logic vld_q, vld_d;

    // Data-valid qualifier: set the cycle after an accepted read
    always_comb begin
      if (clr) begin
        vld_d = 1'b0;
      end else begin
        vld_d = en_o;
      end
    end

    // Data-valid register
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_d;
      end
    end

    assign data_o = vld_q ? data_i : {DW{1'b0}};
  end else begin : g_comb
    assign data_o = en_o ? data_i : {DW{1'b0}};
  end
endmodule

// File: rtl/conv_pool_sched.sv
// conv_pool_sched: layer scheduler for the CONV_POOL datapath. Accepts one
// layer command, pulses start_conv, serves ifm/weight reads from SRAM, writes
// results to the ofm SRAM and flags protocol errors on a sticky err.
// Optional: define CONV_POOL_SCHED_PERF_EN to add the cyc_cnt cycle counter.
module conv_pool_sched
  import conv_pool_pkg::*;
#(
  parameter int IFM_WIDTH    = 16,
  parameter int WEIGHT_WIDTH = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int IFM_SIZE     = 13,
  parameter int KERNEL_SIZE  = 3,
  parameter int CI           = 3,
  parameter int CO           = 16,
  parameter int FINAL_SIZE   = 6,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                    clk1,
  input  logic                    rst,
  conv_pool_sched_if.slave        bus,
  output logic                    ifm_rd_en,
  output logic [ADDR_WIDTH-1:0]   ifm_addr,
  input  logic [IFM_WIDTH-1:0]    ifm_mem_data,
  output logic                    wgt_rd_en,
  output logic [ADDR_WIDTH-1:0]   wgt_addr,
  input  logic [WEIGHT_WIDTH-1:0] wgt_mem_data,
  output logic                    ofm_we,
  output logic [ADDR_WIDTH-1:0]   ofm_addr,
  output logic [DATA_WIDTH-1:0]   ofm_wdata,
  output logic                    busy,
  output logic                    done,
`ifdef CONV_POOL_SCHED_PERF_EN
  output logic [31:0]             cyc_cnt,
`endif
  output logic                    err
);
  localparam int IFM_T = CI * IFM_SIZE * IFM_SIZE;
  localparam int WGT_T = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
  localparam int OFM_T = CO * FINAL_SIZE * FINAL_SIZE;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ifm_base_q, ifm_base_d;
  logic [ADDR_WIDTH-1:0]   wgt_base_q, wgt_base_d;
  logic [ADDR_WIDTH-1:0]   ofm_base_q, ofm_base_d;
  logic                    err_q, err_d;
  logic                    accept_s, run_s, start_s;
  logic                    ifm_req_s, wgt_req_s, ofm_req_s;
  logic                    stray_s, overflow_s, short_s, ofm_full_nxt_s;
  logic                    ifm_full_unused, wgt_full_unused;
  logic [IFM_WIDTH-1:0]    ifm_s;
  logic [WEIGHT_WIDTH-1:0] wgt_s;

  assign run_s   = (state_q == S_RUN);
  assign start_s = (state_q == S_START);

  // The weight prefetch in START also absorbs any wgt_read seen there
  assign ifm_req_s = run_s & bus.ifm_read;
  assign wgt_req_s = start_s | (run_s & bus.wgt_read);
  assign ofm_req_s = run_s & bus.out_valid;

  assign stray_s    = ~run_s & (bus.ifm_read | bus.out_valid | (bus.wgt_read & ~start_s));
  assign overflow_s = ofm_req_s & ~ofm_we;
  assign short_s    = run_s & bus.end_pool & ~ofm_full_nxt_s;

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.start_conv = start_s;
  assign bus.ifm        = ifm_s;
  assign bus.wgt        = wgt_s;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;

  // Layer FSM, base latching and sticky error update
  always_comb begin
    state_d    = state_q;
    ifm_base_d = ifm_base_q;
    wgt_base_d = wgt_base_q;
    ofm_base_d = ofm_base_q;
    accept_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept_s   = 1'b1;
          ifm_base_d = bus.cmd_ifm_base;
          wgt_base_d = bus.cmd_wgt_base;
          ofm_base_d = bus.cmd_ofm_base;
          state_d    = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (bus.end_pool) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    err_d = (accept_s ? 1'b0 : err_q) | stray_s | overflow_s | short_s;
  end

  // State, base and error registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ifm_base_q <= {ADDR_WIDTH{1'b0}};
      wgt_base_q <= {ADDR_WIDTH{1'b0}};
      ofm_base_q <= {ADDR_WIDTH{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ifm_base_q <= ifm_base_d;
      wgt_base_q <= wgt_base_d;
      ofm_base_q <= ofm_base_d;
      err_q      <= err_d;
    end
  end

  sched_addr_gen #(.AW(ADDR_WIDTH), .DW(IFM_WIDTH), .TOTAL(IFM_T), .WRAP(1'b1), .REG_DATA(1'b1)) u_ifm (
    .clk(clk1), .rst(rst), .clr(accept_s), .req(ifm_req_s), .base(ifm_base_q),
    .data_i(ifm_mem_data), .en_o(ifm_rd_en), .addr_o(ifm_addr), .data_o(ifm_s),
    .full_nxt_o(ifm_full_unused)
  );

  sched_addr_gen #(.AW(ADDR_WIDTH), .DW(WEIGHT_WIDTH), .TOTAL(WGT_T), .WRAP(1'b1), .REG_DATA(1'b1)) u_wgt (
    .clk(clk1), .rst(rst), .clr(accept_s), .req(wgt_req_s), .base(wgt_base_q),
    .data_i(wgt_mem_data), .en_o(wgt_rd_en), .addr_o(wgt_addr), .data_o(wgt_s),
    .full_nxt_o(wgt_full_unused)
  );

  sched_addr_gen #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .TOTAL(OFM_T), .WRAP(1'b0), .REG_DATA(1'b0)) u_ofm (
    .clk(clk1), .rst(rst), .clr(accept_s), .req(ofm_req_s), .base(ofm_base_q),
    .data_i(bus.data_output), .en_o(ofm_we), .addr_o(ofm_addr), .data_o(ofm_wdata),
    .full_nxt_o(ofm_full_nxt_s)
  );

`ifdef CONV_POOL_SCHED_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  // Cycle count from START through DONE; cleared on accept, held in IDLE
  always_comb begin
    if (accept_s) begin
      cyc_d = 32'd0;
    end else if (state_q != S_IDLE) begin
      cyc_d = cyc_q + 32'd1;
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Cycle counter register
  always_ff @(posedge clk1) begin
    if (rst) begin
      cyc_q <= 32'd0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_cnt = cyc_q;
`endif
endmodule
